// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : Pipeline status inputs and latch-control outputs of the hazard
//           controller. stall_cycles exists only when PIPE_PERF_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    logic        ihit;
    logic        dhit;
    logic        mem_req;
    logic        br_taken;
    logic        idex_memRead;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        halt_wb;

    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic        exmem_en;
    logic        exmem_flush;
    logic        memwb_en;
    logic        memwb_flush;
    logic        halted;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_cycles;
`endif

    // master: the pipeline datapath; slave: the hazard controller
    modport master (
        output ihit, dhit, mem_req, br_taken, idex_memRead, idex_rd,
               ifid_rs1, ifid_rs2, halt_wb,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, halted
`ifdef PIPE_PERF_EN
        , input stall_cycles
`endif
    );

    modport slave (
        input  ihit, dhit, mem_req, br_taken, idex_memRead, idex_rd,
               ifid_rs1, ifid_rs2, halt_wb,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, halted
`ifdef PIPE_PERF_EN
        , output stall_cycles
`endif
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Five-stage pipeline hazard/stall controller (RUN/DWAIT/HALTED).
//           Optional stall counter enabled by macro PIPE_PERF_EN.
// Rev     : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl (
    input  wire logic          CLK,
    input  wire logic          RST,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_halted;

    logic   w_pc_en;
    logic   w_ifid_en,  w_ifid_flush;
    logic   w_idex_en,  w_idex_flush;
    logic   w_exmem_en, w_exmem_flush;
    logic   w_memwb_en, w_memwb_flush;

    logic   w_load_use;
    logic   w_dmiss;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard
    assign w_load_use = hz.idex_memRead && (hz.idex_rd != 5'd0) &&
                        ((hz.idex_rd == hz.ifid_rs1) || (hz.idex_rd == hz.ifid_rs2));
    assign w_dmiss    = hz.mem_req && !hz.dhit;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_en     = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_en    = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_en    = 1'b0;
        w_memwb_flush = 1'b0;

        if (RST) begin
            w_state_nxt   = RUN;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_memwb_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (hz.halt_wb) begin
                        w_state_nxt = HALTED;
                    end else if (w_dmiss) begin
                        w_memwb_flush = 1'b1;
                        w_state_nxt   = DWAIT;
                    end else if (hz.br_taken) begin
                        // wrong-path IF and ID instructions are squashed
                        w_pc_en      = 1'b1;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                        w_exmem_en   = 1'b1;
                        w_memwb_en   = 1'b1;
                    end else if (w_load_use) begin
                        w_idex_flush = 1'b1;
                        w_exmem_en   = 1'b1;
                        w_memwb_en   = 1'b1;
                    end else if (!hz.ihit) begin
                        w_ifid_flush = 1'b1;
                        w_idex_en    = 1'b1;
                        w_exmem_en   = 1'b1;
                        w_memwb_en   = 1'b1;
                    end else begin
                        w_pc_en    = 1'b1;
                        w_ifid_en  = 1'b1;
                        w_idex_en  = 1'b1;
                        w_exmem_en = 1'b1;
                        w_memwb_en = 1'b1;
                    end
                end
                DWAIT: begin
                    // br_taken is ignored here: EX is frozen and re-presents it
                    if (hz.halt_wb) begin
                        w_state_nxt = HALTED;
                    end else if (!hz.dhit) begin
                        w_memwb_flush = 1'b1;
                    end else begin
                        w_pc_en     = 1'b1;
                        w_ifid_en   = 1'b1;
                        w_idex_en   = 1'b1;
                        w_exmem_en  = 1'b1;
                        w_memwb_en  = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                HALTED: begin
                    w_state_nxt = HALTED;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= (w_state_nxt == HALTED);
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] r_stall_cnt;

    // saturating count of cycles in which the PC did not advance
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state != HALTED) && !w_pc_en && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign hz.stall_cycles = r_stall_cnt;
`endif

    assign hz.pc_en       = w_pc_en;
    assign hz.ifid_en     = w_ifid_en;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.idex_en     = w_idex_en;
    assign hz.idex_flush  = w_idex_flush;
    assign hz.exmem_en    = w_exmem_en;
    assign hz.exmem_flush = w_exmem_flush;
    assign hz.memwb_en    = w_memwb_en;
    assign hz.memwb_flush = w_memwb_flush;
    assign hz.halted      = r_halted;

    a_ifid_excl:  assert property (@(posedge CLK) !(w_ifid_en  && w_ifid_flush));
    a_idex_excl:  assert property (@(posedge CLK) !(w_idex_en  && w_idex_flush));
    a_exmem_excl: assert property (@(posedge CLK) !(w_exmem_en && w_exmem_flush));
    a_memwb_excl: assert property (@(posedge CLK) !(w_memwb_en && w_memwb_flush));

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Scoreboard bench for pipe_hazard_ctrl (directed + random cycles),
//           with stall counter checks when PIPE_PERF_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .hz  (hz)
    );

    // per-latch action as {en, flush}
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] ADV  = 2'b10;
    localparam logic [1:0] CLR  = 2'b01;

    typedef struct packed {
        logic [8:0]  ctl;
        logic        halted;
        logic [31:0] stall;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   stim_done = 1'b0;

    // reference state: are we waiting on data, are we halted, stall count
    bit     m_waiting = 1'b0, m_halted = 1'b0;
    longint m_stall   = 0;
    bit     n_waiting = 1'b0, n_halted = 1'b0;
    longint n_stall   = 0;
    bit     preset_pending = 1'b0;

    function automatic logic [8:0] act(input bit pc, input logic [1:0] a_ifid,
                                       input logic [1:0] a_idex, input logic [1:0] a_exmem,
                                       input logic [1:0] a_memwb);
        return {pc, a_ifid, a_idex, a_exmem, a_memwb};
    endfunction

    function automatic logic [8:0] expect_ctl();
        bit hazard;
        hazard = hz.idex_memRead && (hz.idex_rd != 0) &&
                 (hz.idex_rd == hz.ifid_rs1 || hz.idex_rd == hz.ifid_rs2);
        if (RST)                       return act(0, CLR, CLR, CLR, CLR);
        if (m_halted || hz.halt_wb)    return act(0, HOLD, HOLD, HOLD, HOLD);
        if (m_waiting)                 return hz.dhit ? act(1, ADV, ADV, ADV, ADV)
                                                      : act(0, HOLD, HOLD, HOLD, CLR);
        if (hz.mem_req && !hz.dhit)    return act(0, HOLD, HOLD, HOLD, CLR);
        if (hz.br_taken)               return act(1, CLR, CLR, ADV, ADV);
        if (hazard)                    return act(0, HOLD, CLR, ADV, ADV);
        if (!hz.ihit)                  return act(0, CLR, ADV, ADV, ADV);
        return act(1, ADV, ADV, ADV, ADV);
    endfunction

    task automatic cyc(input logic rst, input logic ihit, input logic dhit,
                       input logic mem_req, input logic br, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic halt);
        logic [8:0] ctl;
        exp_t e;
        @(posedge CLK);
        #1;
        m_waiting = n_waiting;
        m_halted  = n_halted;
        m_stall   = n_stall;
`ifdef PIPE_PERF_EN
        if (preset_pending) begin
            force dut.r_stall_cnt = 32'hFFFF_FFFE;
            release dut.r_stall_cnt;
            m_stall = 64'h0000_0000_FFFF_FFFE;
        end
`endif
        preset_pending = 1'b0;
        RST             = rst;
        hz.ihit         = ihit;
        hz.dhit         = dhit;
        hz.mem_req      = mem_req;
        hz.br_taken     = br;
        hz.idex_memRead = mr;
        hz.idex_rd      = rd;
        hz.ifid_rs1     = rs1;
        hz.ifid_rs2     = rs2;
        hz.halt_wb      = halt;
        ctl = expect_ctl();
        e.ctl    = ctl;
        e.halted = m_halted;
        e.stall  = m_stall[31:0];
        sb_q.push_back(e);

        n_waiting = m_waiting;
        n_halted  = m_halted;
        n_stall   = m_stall;
        if (rst) begin
            n_waiting = 1'b0;
            n_halted  = 1'b0;
            n_stall   = 0;
        end else if (!m_halted) begin
            if (!ctl[8] && m_stall < 64'h0000_0000_FFFF_FFFF) n_stall = m_stall + 1;
            if (halt)           begin n_halted = 1'b1; n_waiting = 1'b0; end
            else if (m_waiting) n_waiting = !dhit;
            else                n_waiting = mem_req && !dhit;
        end
    endtask

    task automatic run_cycle(input logic ihit, input logic dhit, input logic mem_req,
                             input logic br, input logic halt);
        cyc(1'b0, ihit, dhit, mem_req, br, 1'b0, 5'd0, 5'd1, 5'd2, halt);
    endtask

    // monitor: one expected entry per cycle, compared mid-cycle
    initial begin
        exp_t       e;
        logic [8:0] got;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
                       hz.exmem_en, hz.exmem_flush, hz.memwb_en, hz.memwb_flush};
                n_checks++;
                if (got !== e.ctl) begin
                    n_errors++;
                    $display("FAIL ctl t=%0t got=%b want=%b", $time, got, e.ctl);
                end
                n_checks++;
                if ((got[7] & got[6]) | (got[5] & got[4]) | (got[3] & got[2]) | (got[1] & got[0])) begin
                    n_errors++;
                    $display("FAIL excl t=%0t got=%b want no en&flush pair", $time, got);
                end
                n_checks++;
                if (hz.halted !== e.halted) begin
                    n_errors++;
                    $display("FAIL halted t=%0t got=%b want=%b", $time, hz.halted, e.halted);
                end
`ifdef PIPE_PERF_EN
                n_checks++;
                if (hz.stall_cycles !== e.stall) begin
                    n_errors++;
                    $display("FAIL stall t=%0t got=%h want=%h", $time, hz.stall_cycles, e.stall);
                end
`endif
            end
        end
    end

    initial begin
        hz.ihit = 1'b1; hz.dhit = 1'b1; hz.mem_req = 1'b0; hz.br_taken = 1'b0;
        hz.idex_memRead = 1'b0; hz.idex_rd = 5'd0; hz.ifid_rs1 = 5'd0;
        hz.ifid_rs2 = 5'd0; hz.halt_wb = 1'b0;

        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 1, 0, 0, 0);
        // load-use stalls exactly once, then the bubble releases it
        cyc(0, 1, 1, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
        cyc(0, 1, 1, 0, 0, 0, 5'd0, 5'd1, 5'd5, 0);
        cyc(0, 1, 1, 0, 0, 1, 5'd0, 5'd0, 5'd3, 0);
        // data wait of three cycles
        repeat (3) run_cycle(1, 0, 1, 0, 0);
        run_cycle(1, 1, 1, 0, 0);
        run_cycle(1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 1, 5'd7, 5'd7, 5'd2, 0);
        run_cycle(0, 1, 0, 0, 0);
        // redirect held off during DWAIT
        run_cycle(1, 0, 1, 0, 0);
        run_cycle(1, 0, 1, 1, 0);
        run_cycle(0, 1, 1, 1, 0);
        run_cycle(1, 1, 0, 1, 0);
        // reset abandons DWAIT
        run_cycle(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 1, 0, 0, 0);
        // halt, ignored activity, then reset
        run_cycle(1, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++)
            run_cycle(logic'(i[0]), logic'(i[1]), 1'b1, logic'(~i[0]), 1'b0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(1, 1, 0, 0, 0);
        // halt while in DWAIT
        run_cycle(1, 0, 1, 0, 0);
        run_cycle(1, 0, 1, 0, 1);
        run_cycle(1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_PERF_EN
        preset_pending = 1'b1;
        repeat (3) run_cycle(0, 1, 0, 0, 0);
        run_cycle(1, 1, 0, 0, 0);
        run_cycle(0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
`endif
        for (int i = 0; i < 500; i++) begin
            cyc(logic'($urandom_range(99) < 3),
                logic'($urandom_range(99) < 80),
                logic'($urandom_range(99) < 50),
                logic'($urandom_range(99) < 35),
                logic'($urandom_range(99) < 20),
                logic'($urandom_range(99) < 45),
                5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                logic'($urandom_range(99) < 2));
        end
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        wait (stim_done);
        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge CLK);
            budget--;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain got=%0d pending want=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have the following ports, one per line, clock and reset first:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_req  in  1  EX/MEM stage holds a load or store (dREN|dWEN).
- br_taken  in  1  EX stage resolved a redirect (taken branch, jal, jalr).
- idex_memRead  in  1  ID/EX stage holds a load.
- idex_rd  in  5  destination register of ID/EX instruction.
- ifid_rs1, ifid_rs2  in  5 each  source registers of IF/ID instruction.
- halt_wb  in  1  halt flag at MEM/WB output.
- pc_en  out  1  PC register update enable.
- ifid_en, ifid_flush  out  1 each  IF/ID latch control.
- idex_en, idex_flush  out  1 each  ID/EX latch control.
- exmem_en, exmem_flush  out  1 each  EX/MEM latch control.
- memwb_en, memwb_flush  out  1 each  MEM/WB latch control.
- halted  out  1  core halted, sticky.
- stall_cycles  out  32  stall counter (present only with PIPE_PERF_EN).

Function
REQ-002 SHALL implement FSM states RUN, DWAIT, HALTED; all outputs are combinational from state and inputs, except halted and stall_cycles, which are registered.
REQ-003 Per latch, en and flush SHALL never both be 1 in the same cycle.
REQ-004 Priority within RUN, highest first: halt, data wait, redirect, load-use, instruction wait, normal.
REQ-005 Halt: halt_wb=1 in RUN or DWAIT -> all en=0 and all flush=0 that cycle; next state HALTED.
REQ-006 HALTED: all en=0, all flush=0, pc_en=0, halted=1; exits only on RST.
REQ-007 Data wait: mem_req=1 and dhit=0 -> pc_en, ifid_en, idex_en, exmem_en, memwb_en = 0; memwb_flush=1 (bubble into WB); next state DWAIT.
REQ-008 DWAIT with dhit=0: same outputs as REQ-007; stay in DWAIT.
REQ-009 DWAIT with dhit=1: all en=1 and all flush=0; next state RUN.
REQ-010 Redirect: br_taken=1 -> pc_en=1; ifid_flush=1; idex_flush=1; exmem_en=1; memwb_en=1.
REQ-011 Redirect beats load-use in the same cycle, because the ID instruction is wrong-path.
REQ-012 Load-use: idex_memRead=1, idex_rd!=0, and idex_rd equal to ifid_rs1 or ifid_rs2 -> pc_en=0; ifid_en=0; idex_flush=1; exmem_en=1; memwb_en=1.
REQ-013 Instruction wait: ihit=0 -> pc_en=0; ifid_flush=1; idex_en, exmem_en and memwb_en = 1.
REQ-014 Normal: all en=1, all flush=0.
REQ-015 A redirect arriving during DWAIT SHALL NOT be acted on until the DWAIT exit cycle; EX is frozen, so br_taken is re-presented.

Reset
REQ-016 While RST=1 at a rising edge, state SHALL become RUN, halted=0, and stall_cycles=0.
REQ-017 While RST=1, all en outputs SHALL be 0 and all flush outputs SHALL be 1, so every latch clears.
REQ-018 Reset asserted mid-DWAIT or in HALTED SHALL abandon that state with no residual effect.

Configuration
REQ-019 With macro PIPE_PERF_EN defined, stall_cycles SHALL increment by 1 on each rising edge where state!=HALTED and pc_en=0.
REQ-020 stall_cycles SHALL saturate at 32'hFFFF_FFFF and SHALL NOT wrap.
REQ-021 Without PIPE_PERF_EN, the stall_cycles port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- Load-use: idex_memRead=1, idex_rd=5, ifid_rs2=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle.
- Load to x0: idex_memRead=1, idex_rd=0, ifid_rs1=0 -> no stall, all en=1.
- Data wait: mem_req=1, dhit=0 for 3 cycles, then dhit=1 -> memwb_flush=1 and other en=0 for 3 cycles; all en=1 on the dhit cycle; state returns to RUN; stall_cycles +3 (PIPE_PERF_EN).
- Redirect vs load-use: br_taken=1 and load-use hazard together -> pc_en=1, ifid_flush=1, idex_flush=1.
- Halt: halt_wb=1 -> next cycle halted=1 and all en=0; ihit, dhit and br_taken toggling has no effect; RST=1 for one cycle -> halted=0, state RUN.
- Saturation (PIPE_PERF_EN): force stall_cycles to 32'hFFFF_FFFE, then 3 stall cycles -> stall_cycles holds 32'hFFFF_FFFF.
